// File: rtl/ram_wb.sv
// ram_wb: write-back stage of the cpu15 data memory.
// Holds the eight RAM words, commits stores on CLK_WB and owns the IO64
// output port with a valid/ack handshake backed by a one-entry pending buffer.
module ram_wb #(
    parameter int         DATA_W      = 16,
    parameter logic [7:0] IO_OUT_ADDR = 8'd64
) (
    input  logic              CLK_WB,
    input  logic              RESET,
    input  logic              RAM_WEN,
    input  logic [7:0]        RAM_AD_IN,
    input  logic [DATA_W-1:0] RAM_IN,
    output logic [DATA_W-1:0] RAM_0,
    output logic [DATA_W-1:0] RAM_1,
    output logic [DATA_W-1:0] RAM_2,
    output logic [DATA_W-1:0] RAM_3,
    output logic [DATA_W-1:0] RAM_4,
    output logic [DATA_W-1:0] RAM_5,
    output logic [DATA_W-1:0] RAM_6,
    output logic [DATA_W-1:0] RAM_7,
    output logic [DATA_W-1:0] IO64_OUT,
    output logic              IO64_VALID,
    input  logic              IO64_ACK,
    output logic              IO64_FULL,
    output logic              WR_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        FULL = 2'b10
    } io_state_t;

    io_state_t         state, state_nxt;
    logic [DATA_W-1:0] mem [8];
    logic [DATA_W-1:0] io_out, io_out_nxt;
    logic [DATA_W-1:0] pend, pend_nxt;
    logic              wr_err, wr_err_nxt;
    logic              ram_hit, io_hit, unmapped;

    // Address decode of the store request
    always_comb begin
        ram_hit  = RAM_WEN && (RAM_AD_IN[7:3] == 5'd0);
        io_hit   = RAM_WEN && (RAM_AD_IN == IO_OUT_ADDR);
        unmapped = RAM_WEN && !ram_hit && !io_hit;
    end

    // IO64 handshake next-state, output word, pending word and error pulse
    always_comb begin
        state_nxt  = state;
        io_out_nxt = io_out;
        pend_nxt   = pend;
        wr_err_nxt = unmapped;
        case (state)
            IDLE: begin
                if (io_hit) begin
                    io_out_nxt = RAM_IN;
                    state_nxt  = SHOW;
                end
            end
            SHOW: begin
                if (IO64_ACK && io_hit) begin
                    io_out_nxt = RAM_IN;
                end else if (IO64_ACK) begin
                    state_nxt = IDLE;
                end else if (io_hit) begin
                    pend_nxt  = RAM_IN;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (IO64_ACK && io_hit) begin
                    io_out_nxt = pend;
                    pend_nxt   = RAM_IN;
                end else if (IO64_ACK) begin
                    io_out_nxt = pend;
                    state_nxt  = SHOW;
                end else if (io_hit) begin
                    // Buffer already occupied: the store is lost
                    wr_err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // IO64 state, presented word, pending word and error register
    always_ff @(posedge CLK_WB) begin
        if (RESET) begin
            state  <= IDLE;
            io_out <= '0;
            pend   <= '0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            io_out <= io_out_nxt;
            pend   <= pend_nxt;
            wr_err <= wr_err_nxt;
        end
    end

    // RAM word commit; stores to 0..7 never stall
    always_ff @(posedge CLK_WB) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (ram_hit) begin
            mem[RAM_AD_IN[2:0]] <= RAM_IN;
        end
    end

    assign RAM_0      = mem[0];
    assign RAM_1      = mem[1];
    assign RAM_2      = mem[2];
    assign RAM_3      = mem[3];
    assign RAM_4      = mem[4];
    assign RAM_5      = mem[5];
    assign RAM_6      = mem[6];
    assign RAM_7      = mem[7];
    assign IO64_OUT   = io_out;
    assign IO64_VALID = (state == SHOW) || (state == FULL);
    assign IO64_FULL  = (state == FULL);
    assign WR_ERR     = wr_err;

endmodule

// File: tb/tb_ram_wb.sv
// tb_ram_wb: directed and randomized stimulus for ram_wb, compared every
// cycle against a queue-based model of the memory and the IO64 word stream.
module tb_ram_wb;

    logic        clk_wb = 1'b0;
    logic        reset;
    logic        ram_wen;
    logic [7:0]  ram_ad_in;
    logic [15:0] ram_in;
    logic [15:0] ram_0, ram_1, ram_2, ram_3, ram_4, ram_5, ram_6, ram_7;
    logic [15:0] io64_out;
    logic        io64_valid;
    logic        io64_ack;
    logic        io64_full;
    logic        wr_err;

    int checks = 0;
    int errors = 0;

    // Reference model: RAM array, FIFO of words owed to the device (max 2),
    // last word shown, expected error pulse
    logic [15:0] m_ram [8];
    logic [15:0] m_q [$];
    logic [15:0] m_last;
    logic        m_err;

    ram_wb dut (
        .CLK_WB     (clk_wb),
        .RESET      (reset),
        .RAM_WEN    (ram_wen),
        .RAM_AD_IN  (ram_ad_in),
        .RAM_IN     (ram_in),
        .RAM_0      (ram_0),
        .RAM_1      (ram_1),
        .RAM_2      (ram_2),
        .RAM_3      (ram_3),
        .RAM_4      (ram_4),
        .RAM_5      (ram_5),
        .RAM_6      (ram_6),
        .RAM_7      (ram_7),
        .IO64_OUT   (io64_out),
        .IO64_VALID (io64_valid),
        .IO64_ACK   (io64_ack),
        .IO64_FULL  (io64_full),
        .WR_ERR     (wr_err)
    );

    always #5 clk_wb = ~clk_wb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic wen, input logic [7:0] ad,
                              input logic [15:0] d, input logic ack);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_ram[i] = '0;
            m_q.delete();
            m_last = '0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (ack && m_q.size() > 0) void'(m_q.pop_front());
            if (wen) begin
                if (ad < 8'd8) m_ram[ad[2:0]] = d;
                else if (ad == 8'd64) begin
                    if (m_q.size() < 2) m_q.push_back(d);
                    else m_err = 1'b1;
                end else m_err = 1'b1;
            end
            if (m_q.size() > 0) m_last = m_q[0];
        end
    endtask

    task automatic compare_all();
        logic [15:0] got_ram [8];
        got_ram = '{ram_0, ram_1, ram_2, ram_3, ram_4, ram_5, ram_6, ram_7};
        for (int i = 0; i < 8; i++) chk($sformatf("ram%0d", i), {16'd0, got_ram[i]}, {16'd0, m_ram[i]});
        chk("io_out", {16'd0, io64_out}, {16'd0, m_last});
        chk("valid", {31'd0, io64_valid}, {31'd0, (m_q.size() > 0)});
        chk("full", {31'd0, io64_full}, {31'd0, (m_q.size() == 2)});
        chk("wr_err", {31'd0, wr_err}, {31'd0, m_err});
    endtask

    // One clock: drive inputs, update the model at the edge, check 1 time unit later
    task automatic step(input logic rst, input logic wen, input logic [7:0] ad,
                        input logic [15:0] d, input logic ack);
        reset = rst; ram_wen = wen; ram_ad_in = ad; ram_in = d; io64_ack = ack;
        @(posedge clk_wb);
        model_edge(rst, wen, ad, d, ack);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; ram_wen = 1'b0; ram_ad_in = '0; ram_in = '0; io64_ack = 1'b0;
        for (int i = 0; i < 8; i++) m_ram[i] = '0;
        m_last = '0; m_err = 1'b0;

        // Reset then idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // RAM stores and unmapped store
        step(0, 1, 8'd3, 16'h1234, 0);
        chk("ram3_direct", {16'd0, ram_3}, 32'h1234);
        step(0, 1, 8'd7, 16'hBEEF, 0);
        chk("ram7_direct", {16'd0, ram_7}, 32'hBEEF);
        step(0, 1, 8'd9, 16'hFFFF, 0);
        chk("err_pulse", {31'd0, wr_err}, 32'd1);
        step(0, 0, 0, 0, 0);
        chk("err_cleared", {31'd0, wr_err}, 32'd0);

        // IO64 basic handshake
        step(0, 1, 8'd64, 16'h00A5, 0);
        chk("io_a5", {16'd0, io64_out}, 32'h00A5);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("io_a5_kept", {16'd0, io64_out}, 32'h00A5);
        chk("valid_drop", {31'd0, io64_valid}, 32'd0);

        // Buffering and overflow
        step(0, 1, 8'd64, 16'h0001, 0);
        step(0, 1, 8'd64, 16'h0002, 0);
        step(0, 1, 8'd64, 16'h0003, 0);
        chk("ovf_err", {31'd0, wr_err}, 32'd1);
        step(0, 0, 0, 0, 1);
        chk("pend_out", {16'd0, io64_out}, 32'h0002);
        step(0, 0, 0, 0, 1);
        chk("drained", {31'd0, io64_valid}, 32'd0);

        // Simultaneous ACK and store in FULL, then in SHOW
        step(0, 1, 8'd64, 16'h0010, 0);
        step(0, 1, 8'd64, 16'h0020, 0);
        step(0, 1, 8'd64, 16'h0030, 1);
        chk("full_ackw_out", {16'd0, io64_out}, 32'h0020);
        chk("full_ackw_full", {31'd0, io64_full}, 32'd1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 8'd64, 16'h0040, 1);
        chk("show_ackw_out", {16'd0, io64_out}, 32'h0040);
        chk("show_ackw_valid", {31'd0, io64_valid}, 32'd1);

        // Reset mid-operation
        step(0, 1, 8'd64, 16'h0050, 0);
        step(1, 1, 8'd64, 16'h0060, 1);
        chk("rst_out", {16'd0, io64_out}, 32'h0000);
        step(0, 0, 0, 0, 1);
        chk("idle_ack_ignored", {31'd0, io64_valid}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ad;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) ad = 8'($urandom_range(0, 7));
            else if (sel < 8) ad = 8'd64;
            else ad = 8'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), ad,
                 16'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_wb.md
Name: ram_wb

Overview:
- Write-back stage of the cpu15 data memory.
- Holds the eight 16-bit RAM words and drives them as RAM_0..RAM_7 into the RAM decode stage.
- Commits store writes from the execute stage on CLK_WB.
- Owns the IO64 output port, a memory-mapped output word presented to an external device through a valid/ack handshake with a one-entry pending buffer.

Parameters:
- DATA_W, 16, data word width; all RAM words, RAM_IN and IO64_OUT use it.
- IO_OUT_ADDR, 8'd64, address decoded as the IO64 output port.

Ports:
- CLK_WB  in  1  write-back clock; all state changes on its rising edge.
- RESET  in  1  synchronous reset, active-high.
- RAM_WEN  in  1  store request; sampled every rising edge.
- RAM_AD_IN  in  8  store address.
- RAM_IN  in  DATA_W  store data.
- RAM_0 .. RAM_7  out  DATA_W each  current contents of RAM words 0..7.
- IO64_OUT  out  DATA_W  word currently presented on the output port.
- IO64_VALID  out  1  IO64_OUT holds a word not yet acknowledged.
- IO64_ACK  in  1  external device has consumed IO64_OUT; only meaningful while IO64_VALID=1.
- IO64_FULL  out  1  pending buffer occupied; a further IO64 store is lost.
- WR_ERR  out  1  one-cycle pulse on a dropped store (unmapped address or IO64 overflow).

Behaviour:
- Reset: when RESET=1 at a rising edge, all of the following clear and every other input is ignored that cycle:
  - RAM_0..RAM_7=0, IO64_OUT=0, pending buffer=0
  - IO64_VALID=0, IO64_FULL=0, WR_ERR=0, state=IDLE
- Reset mid-handshake discards both the presented word and the pending word.
- Address decode applies only when RAM_WEN=1:
  - 0..7: RAM word [2:0] <= RAM_IN.
  - IO_OUT_ADDR: IO64 path (below).
  - Anything else: no state change; WR_ERR=1 for the next cycle.
- RAM store latency: RAM_n shows the new value from the clock edge that samples RAM_WEN, so it is visible to the decode stage on its next CLK_DC. RAM stores never stall.
- WR_ERR is registered: high for exactly one cycle after the offending edge, low otherwise.
- IO64 state machine, evaluated on each edge; W = RAM_WEN=1 and RAM_AD_IN=IO_OUT_ADDR, A = IO64_ACK.
  - IDLE (VALID=0, FULL=0):
    - W: IO64_OUT<=RAM_IN, go SHOW.
    - A is ignored.
  - SHOW (VALID=1, FULL=0):
    - A and W: IO64_OUT<=RAM_IN, stay SHOW. The old word completes and the new one is presented with no gap.
    - A only: go IDLE; IO64_OUT retains its last value.
    - W only: pending<=RAM_IN, go FULL.
  - FULL (VALID=1, FULL=1):
    - A and W: IO64_OUT<=pending, pending<=RAM_IN, stay FULL.
    - A only: IO64_OUT<=pending, go SHOW.
    - W only: the store is dropped, WR_ERR pulses, and IO64_OUT and pending are unchanged.
- IO64_VALID and IO64_FULL are decoded directly from state registers; no combinational path from any input.
- IO64_OUT is stable while IO64_VALID=1 and A=0.
- Word order to the device is strict store order; at most one word is lost per overflowing store.
- Illegal or unused state encodings recover to IDLE on the next edge.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles, release -> RAM_0..7=0, IO64_OUT=0, VALID=0, FULL=0, WR_ERR=0.
- RAM stores: write 8'd3 <- 16'h1234, then 8'd7 <- 16'hBEEF -> RAM_3=16'h1234 the edge after the first store, RAM_7=16'hBEEF the edge after the second, other words 0. Write 8'd9 <- 16'hFFFF -> WR_ERR high exactly one cycle, no RAM change.
- IO64 basic handshake: store 64 <- 16'h00A5 -> IO64_OUT=16'h00A5 and VALID=1 next cycle. Hold ACK=0 for 3 cycles -> unchanged. ACK=1 one cycle -> VALID=0, IO64_OUT still 16'h00A5.
- Buffering: store 64<-16'h0001, then 64<-16'h0002 with no ACK -> OUT=0001, FULL=1.
  - Third store 64<-16'h0003 -> WR_ERR pulse, OUT/pending unchanged.
  - ACK -> OUT=0002, FULL=0.
  - ACK -> VALID=0. The 0003 word never appears.
- Simultaneous ACK+store: in FULL with OUT=0x0010, pending=0x0020, assert ACK and store 64<-0x0030 in the same cycle -> OUT=0x0020, pending=0x0030, FULL stays 1. Then ACK+store in SHOW -> new word presented, VALID never drops.
- Reset mid-operation: in FULL, assert RESET together with ACK and a store to 64 -> all outputs 0 next cycle. A later ACK while IDLE is ignored.
